// File: rtl/isa_pkg.sv
// Shared definitions for the 16-bit ISA: operation codes, instruction field positions,
// error codes and encoder states. The instruction decoder uses the same package.
package isa_pkg;

    typedef enum logic [3:0] {
        EXT_WAIT = 4'h0, EXT_AND  = 4'h1, EXT_OR   = 4'h2, EXT_XOR  = 4'h3,
        EXT_NOT  = 4'h4, EXT_ADD  = 4'h5, EXT_ADDU = 4'h6, EXT_ADDC = 4'h7,
        EXT_RSH  = 4'h8, EXT_SUB  = 4'h9, EXT_SUBC = 4'hA, EXT_CMP  = 4'hB,
        EXT_LSH  = 4'hC, EXT_MOV  = 4'hD, EXT_MUL  = 4'hE, EXT_ARSH = 4'hF
    } ext_code_e;

    // Field LSB positions; both forms share the rdest slot.
    localparam int IMM_OP_LSB  = 12;
    localparam int RDEST_LSB   = 8;
    localparam int REG_EXT_LSB = 4;
    localparam int RSRC_LSB    = 0;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] ERR_IMM_RANGE  = 2'd2;
    localparam logic [1:0] ERR_ADDR_OVF   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_WRITE, ST_DONE, ST_ERR
    } state_e;

    // The decoder sign-extends imm8, so the upper nine bits must all match.
    function automatic logic imm_fits8(input logic [15:0] v);
        return (&v[15:7]) | ~(|v[15:7]);
    endfunction

    // Logic ops and WAIT have no immediate form.
    function automatic logic imm_op_legal(input logic [3:0] ext);
        return ext > EXT_NOT;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: instruction fields -> 16-bit word plus legality flags.
// Register form puts ext in the middle nibble; immediate form uses ext as the opcode.
module instr_pack
    import isa_pkg::*;
(
    input  logic [3:0]  i_ext_code,
    input  logic        i_imm_sel,
    input  logic [3:0]  i_rdest,
    input  logic [3:0]  i_rsrc,
    input  logic [15:0] i_imm,
    output logic [15:0] o_word,
    output logic        o_illegal,
    output logic        o_range_err
);

    always_comb begin
        o_word = 16'h0000;
        if (i_imm_sel) begin
            o_word[IMM_OP_LSB +: 4] = i_ext_code;
            o_word[RDEST_LSB  +: 4] = i_rdest;
            o_word[7:0]             = i_imm[7:0];
        end else begin
            o_word[RDEST_LSB   +: 4] = i_rdest;
            o_word[REG_EXT_LSB +: 4] = i_ext_code;
            o_word[RSRC_LSB    +: 4] = i_rsrc;
        end
        o_illegal   = i_imm_sel & ~imm_op_legal(i_ext_code);
        o_range_err = i_imm_sel & ~imm_fits8(i_imm);
    end

endmodule

// File: rtl/instr_encoder.sv
// Program writer: accepts instruction fields on a valid/ready stream, packs them and
// writes one word per two cycles to consecutive instruction-memory addresses.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_ext_code,
    input  logic              i_imm_sel,
    input  logic [3:0]        i_rdest,
    input  logic [3:0]        i_rsrc,
    input  logic [15:0]       i_imm,
    input  logic              i_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [ADDR_W-1:0] o_count
);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic [15:0]       r_wdata;
    logic              r_last;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic [15:0]       w_word;
    logic              w_illegal;
    logic              w_range_err;
    logic              w_addr_max;

    instr_pack u_pack (
        .i_ext_code  (i_ext_code),
        .i_imm_sel   (i_imm_sel),
        .i_rdest     (i_rdest),
        .i_rsrc      (i_rsrc),
        .i_imm       (i_imm),
        .o_word      (w_word),
        .o_illegal   (w_illegal),
        .o_range_err (w_range_err)
    );

    assign w_addr_max = &r_addr;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_RUN;
            ST_RUN:   if (i_in_valid) w_state_next = (w_illegal | w_range_err) ? ST_ERR : ST_WRITE;
            ST_WRITE: begin
                if (r_last)          w_state_next = ST_DONE;
                else if (w_addr_max) w_state_next = ST_ERR;
                else                 w_state_next = ST_RUN;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            ST_ERR:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_wdata    <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_addr     <= i_base_addr;
                    r_count    <= '0;
                    r_err      <= 1'b0;
                    r_err_code <= ERR_NONE;
                end
                ST_RUN: if (i_in_valid) begin
                    // Illegal op takes priority when both checks fire.
                    if (w_illegal) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_ILLEGAL_OP;
                    end else if (w_range_err) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_IMM_RANGE;
                    end else begin
                        r_wdata <= w_word;
                        r_last  <= i_last;
                    end
                end
                ST_WRITE: begin
                    r_count <= r_count + 1'b1;
                    if (!r_last) begin
                        if (w_addr_max) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_ADDR_OVF;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign o_in_ready  = (r_state == ST_RUN);
    assign o_mem_we    = (r_state == ST_WRITE);
    assign o_done      = (r_state == ST_DONE);
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed test of instr_encoder: hand-computed words, error paths, address overflow,
// ignored start/valid and asynchronous reset during a write.
module tb_instr_encoder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [3:0]        i_ext_code = '0;
    logic              i_imm_sel = 1'b0;
    logic [3:0]        i_rdest = '0;
    logic [3:0]        i_rsrc = '0;
    logic [15:0]       i_imm = '0;
    logic              i_last = 1'b0;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic              o_done;
    logic              o_err;
    logic [1:0]        o_err_code;
    logic [ADDR_W-1:0] o_count;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_mark;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_ext_code  (i_ext_code),
        .i_imm_sel   (i_imm_sel),
        .i_rdest     (i_rdest),
        .i_rsrc      (i_rsrc),
        .i_imm       (i_imm),
        .i_last      (i_last),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_mem_we) begin
            wr_cnt++;
            $display("write addr=%h data=%h", o_mem_addr, o_mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        i_start     = 1'b1;
        i_base_addr = base;
        step();
        i_start     = 1'b0;
    endtask

    // Returns 1 ns after the handshake edge (WRITE or ERR cycle).
    task automatic send(input logic [3:0] ext, input logic sel, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [15:0] imm, input logic last);
        int n;
        i_ext_code = ext;
        i_imm_sel  = sel;
        i_rdest    = rd;
        i_rsrc     = rs;
        i_imm      = imm;
        i_last     = last;
        i_in_valid = 1'b1;
        n = 0;
        while (!o_in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready_before_hs", {31'd0, o_in_ready}, 32'd1);
        step();
        i_in_valid = 1'b0;
        $display("sent ext=%h sel=%0d rd=%h rs=%h imm=%h last=%0d", ext, sel, rd, rs, imm, last);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
        check("rst_mem_we",   {31'd0, o_mem_we},   32'd0);
        check("rst_done",     {31'd0, o_done},     32'd0);
        check("rst_err",      {31'd0, o_err},      32'd0);
        check("rst_err_code", {30'd0, o_err_code}, 32'd0);
        check("rst_count",    {22'd0, o_count},    32'd0);
        check("rst_addr",     {22'd0, o_mem_addr}, 32'd0);
        check("rst_wdata",    {16'd0, o_mem_wdata}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: ADD r3,r5 register form, single last instruction
        do_start(10'h010);
        send(4'h5, 1'b0, 4'h3, 4'h5, 16'h0000, 1'b1);
        check("t1_we",    {31'd0, o_mem_we},    32'd1);
        check("t1_addr",  {22'd0, o_mem_addr},  32'h010);
        check("t1_wdata", {16'd0, o_mem_wdata}, 32'h0355);
        step();
        check("t1_done",  {31'd0, o_done},      32'd1);
        check("t1_count", {22'd0, o_count},     32'd1);
        step();
        check("t1_done_pulse", {31'd0, o_done}, 32'd0);

        // 2: ADDI r2,#-1 then MOVI r1,#127 last
        do_start(10'h020);
        send(4'h5, 1'b1, 4'h2, 4'hA, 16'hFFFF, 1'b0);
        check("t2_addr0",  {22'd0, o_mem_addr},  32'h020);
        check("t2_wdata0", {16'd0, o_mem_wdata}, 32'h52FF);
        step();
        send(4'hD, 1'b1, 4'h1, 4'hA, 16'h007F, 1'b1);
        check("t2_addr1",  {22'd0, o_mem_addr},  32'h021);
        check("t2_wdata1", {16'd0, o_mem_wdata}, 32'hD17F);
        step();
        check("t2_done",   {31'd0, o_done},  32'd1);
        check("t2_count",  {22'd0, o_count}, 32'd2);
        step();

        // 3: MOVI r1,#200 is out of range
        do_start(10'h030);
        wr_mark = wr_cnt;
        send(4'hD, 1'b1, 4'h1, 4'h0, 16'h00C8, 1'b0);
        check("t3_we",       {31'd0, o_mem_we},   32'd0);
        check("t3_err",      {31'd0, o_err},      32'd1);
        check("t3_err_code", {30'd0, o_err_code}, 32'd2);
        check("t3_ready",    {31'd0, o_in_ready}, 32'd0);
        step();
        check("t3_err_held", {31'd0, o_err}, 32'd1);
        check("t3_no_write", wr_cnt - wr_mark, 32'd0);
        do_start(10'h040);
        check("t3_err_clr",  {31'd0, o_err},      32'd0);
        check("t3_code_clr", {30'd0, o_err_code}, 32'd0);
        check("t3_run",      {31'd0, o_in_ready}, 32'd1);

        // 4: ANDI is illegal; register-form AND with the same fields is fine
        wr_mark = wr_cnt;
        send(4'h1, 1'b1, 4'h4, 4'h6, 16'h0005, 1'b0);
        check("t4_err_code", {30'd0, o_err_code}, 32'd1);
        check("t4_we",       {31'd0, o_mem_we},   32'd0);
        step();
        do_start(10'h050);
        send(4'h1, 1'b0, 4'h4, 4'h6, 16'h0005, 1'b1);
        check("t4_wdata",    {16'd0, o_mem_wdata}, 32'h0416);
        check("t4_addr",     {22'd0, o_mem_addr},  32'h050);
        check("t4_writes",   wr_cnt - wr_mark,     32'd0);
        step();
        check("t4_done", {31'd0, o_done}, 32'd1);
        step();

        // Immediate range edges: -129 rejected, -128 accepted
        do_start(10'h060);
        send(4'h9, 1'b1, 4'h7, 4'h0, 16'hFF7F, 1'b0);
        check("imm_m129_code", {30'd0, o_err_code}, 32'd2);
        step();
        do_start(10'h070);
        send(4'h9, 1'b1, 4'h7, 4'h0, 16'hFF80, 1'b1);
        check("imm_m128_wdata", {16'd0, o_mem_wdata}, 32'h9780);
        check("imm_m128_err",   {31'd0, o_err},       32'd0);
        step();
        step();

        // 5: address overflow at all-ones
        do_start(10'h3FF);
        wr_mark = wr_cnt;
        send(4'h5, 1'b0, 4'h1, 4'h2, 16'h0000, 1'b0);
        check("t5_addr",  {22'd0, o_mem_addr},  32'h3FF);
        check("t5_wdata", {16'd0, o_mem_wdata}, 32'h0152);
        step();
        check("t5_err",      {31'd0, o_err},      32'd1);
        check("t5_err_code", {30'd0, o_err_code}, 32'd3);
        check("t5_count",    {22'd0, o_count},    32'd1);
        check("t5_we",       {31'd0, o_mem_we},   32'd0);
        step();
        step();
        check("t5_one_write", wr_cnt - wr_mark, 32'd1);
        do_start(10'h3FF);
        send(4'h6, 1'b0, 4'h1, 4'h2, 16'h0000, 1'b1);
        check("t5b_wdata", {16'd0, o_mem_wdata}, 32'h0162);
        step();
        check("t5b_done", {31'd0, o_done}, 32'd1);
        check("t5b_err",  {31'd0, o_err},  32'd0);
        step();

        // 6a: in_valid while IDLE is ignored
        wr_mark = wr_cnt;
        i_ext_code = 4'h5; i_imm_sel = 1'b0; i_rdest = 4'h1; i_rsrc = 4'h1; i_last = 1'b1;
        i_in_valid = 1'b1;
        step(); step(); step();
        check("t6_idle_ready",  {31'd0, o_in_ready}, 32'd0);
        check("t6_idle_nowr",   wr_cnt - wr_mark,    32'd0);
        i_in_valid = 1'b0;

        // 6b: start during RUN does not reload the base address
        do_start(10'h100);
        do_start(10'h200);
        check("t6_still_run", {31'd0, o_in_ready}, 32'd1);
        send(4'hB, 1'b0, 4'h2, 4'h3, 16'h0000, 1'b1);
        check("t6_addr",  {22'd0, o_mem_addr},  32'h100);
        check("t6_wdata", {16'd0, o_mem_wdata}, 32'h02B3);
        step();
        step();

        // 6c: asynchronous reset during WRITE
        do_start(10'h110);
        send(4'h5, 1'b0, 4'h3, 4'h4, 16'h0000, 1'b0);
        check("t6_we_before", {31'd0, o_mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_we",    {31'd0, o_mem_we},   32'd0);
        check("t6_rst_addr",  {22'd0, o_mem_addr}, 32'd0);
        check("t6_rst_ready", {31'd0, o_in_ready}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
